// File: rtl/cp0_pkg.sv
// Shared types and constants for the CP0 register bank: FSM states, default
// register indices, exception codes and the CAUSE code field position.
package cp0_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXC  = 2'd1,
        S_ERET = 2'd2
    } cp0_state_e;

    localparam int STATUS_ADDR_DEF = 12;
    localparam int CAUSE_ADDR_DEF  = 13;
    localparam int EPC_ADDR_DEF    = 14;

    localparam int CODE_W   = 5;
    localparam int CAUSE_LO = 2;
    localparam int CAUSE_HI = CAUSE_LO + CODE_W - 1;

    localparam logic [CODE_W-1:0] EXC_SYSCALL = 5'd8;
    localparam logic [CODE_W-1:0] EXC_BREAK   = 5'd9;
    localparam logic [CODE_W-1:0] EXC_TEQ     = 5'd13;

endpackage

// File: rtl/cp0_regfile_ctrl_if.sv
// Request/response bundle between the main control FSM (master) and the CP0
// register bank (slave).
interface cp0_regfile_ctrl_if
    import cp0_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              R_SEL_RD;
    logic              R_SEL_STATUS;
    logic              R_SEL_EPC;
    logic              R_SEL_CAUSE;
    logic [ADDR_W-1:0] CP0_RD;
    logic [DATA_W-1:0] RDATA;
    logic              MTC0;
    logic [DATA_W-1:0] WDATA;
    logic              EXC_REQ;
    logic [CODE_W-1:0] EXC_CODE;
    logic [DATA_W-1:0] EXC_PC;
    logic              ERET_REQ;
    logic              BUSY;
    logic              EXC_ACK;
    logic              EXC_REJ;
    logic              ERET_ACK;
    logic [DATA_W-1:0] EPC_OUT;
    logic [DATA_W-1:0] STATUS_OUT;

    modport master (
        output R_SEL_RD, R_SEL_STATUS, R_SEL_EPC, R_SEL_CAUSE, CP0_RD,
        output MTC0, WDATA, EXC_REQ, EXC_CODE, EXC_PC, ERET_REQ,
        input  RDATA, BUSY, EXC_ACK, EXC_REJ, ERET_ACK, EPC_OUT, STATUS_OUT
    );

    modport slave (
        input  R_SEL_RD, R_SEL_STATUS, R_SEL_EPC, R_SEL_CAUSE, CP0_RD,
        input  MTC0, WDATA, EXC_REQ, EXC_CODE, EXC_PC, ERET_REQ,
        output RDATA, BUSY, EXC_ACK, EXC_REJ, ERET_ACK, EPC_OUT, STATUS_OUT
    );

endinterface

// File: rtl/cp0_r_addr_sel.sv
// Prioritised CP0 read-address select (RD > STATUS > EPC > CAUSE); the valid
// flag drops when nothing is selected or the address is unimplemented.
module cp0_r_addr_sel
    import cp0_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int N_REG       = 32,
    parameter int STATUS_ADDR = STATUS_ADDR_DEF,
    parameter int CAUSE_ADDR  = CAUSE_ADDR_DEF,
    parameter int EPC_ADDR    = EPC_ADDR_DEF
) (
    input  logic              sel_rd,
    input  logic              sel_status,
    input  logic              sel_epc,
    input  logic              sel_cause,
    input  logic [ADDR_W-1:0] cp0_rd,
    output logic [ADDR_W-1:0] r_addr,
    output logic              r_vld
);

    always_comb begin
        r_addr = '0;
        r_vld  = 1'b1;
        if (sel_rd)          r_addr = cp0_rd;
        else if (sel_status) r_addr = ADDR_W'(STATUS_ADDR);
        else if (sel_epc)    r_addr = ADDR_W'(EPC_ADDR);
        else if (sel_cause)  r_addr = ADDR_W'(CAUSE_ADDR);
        else                 r_vld  = 1'b0;
        if (int'(r_addr) >= N_REG) r_vld = 1'b0;
    end

endmodule

// File: rtl/cp0_regfile_ctrl.sv
// CP0 register bank with MFC0/MTC0 access and a one-cycle exception-entry /
// ERET sequencer that shifts the STATUS enable stack.
module cp0_regfile_ctrl
    import cp0_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 5,
    parameter int                N_REG       = 32,
    parameter int                STATUS_ADDR = STATUS_ADDR_DEF,
    parameter int                CAUSE_ADDR  = CAUSE_ADDR_DEF,
    parameter int                EPC_ADDR    = EPC_ADDR_DEF,
    parameter int                STATUS_SH   = 5,
    parameter logic [DATA_W-1:0] STATUS_RST  = 'h1
) (
    input logic                CLK,
    input logic                RST,
    cp0_regfile_ctrl_if.slave  bus
);

    localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;

    cp0_state_e        state_q, state_d;
    logic [DATA_W-1:0] regs_q [N_REG];
    logic [DATA_W-1:0] regs_d [N_REG];
    logic [CODE_W-1:0] exc_code_q, exc_code_d;
    logic [DATA_W-1:0] exc_pc_q, exc_pc_d;
    logic              rej_q, rej_d;

    logic [ADDR_W-1:0] r_addr;
    logic              r_vld;
    logic              idle, ie, exc_take, wr_ok;

    cp0_r_addr_sel #(
        .ADDR_W(ADDR_W), .N_REG(N_REG), .STATUS_ADDR(STATUS_ADDR),
        .CAUSE_ADDR(CAUSE_ADDR), .EPC_ADDR(EPC_ADDR)
    ) u_r_addr_sel (
        .sel_rd(bus.R_SEL_RD), .sel_status(bus.R_SEL_STATUS),
        .sel_epc(bus.R_SEL_EPC), .sel_cause(bus.R_SEL_CAUSE),
        .cp0_rd(bus.CP0_RD), .r_addr(r_addr), .r_vld(r_vld)
    );

    assign idle     = (state_q == S_IDLE);
    assign ie       = regs_q[STATUS_ADDR][0];
    assign exc_take = idle && bus.EXC_REQ && ie;
    // Write index is sliced, so the range check must gate it to avoid aliasing.
    assign wr_ok    = idle && bus.MTC0 && (int'(bus.CP0_RD) < N_REG);

    assign bus.RDATA      = r_vld ? regs_q[r_addr[IDX_W-1:0]] : '0;
    assign bus.EPC_OUT    = regs_q[EPC_ADDR];
    assign bus.STATUS_OUT = regs_q[STATUS_ADDR];
    assign bus.EXC_REJ    = rej_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            exc_code_q <= '0;
            exc_pc_q   <= '0;
            rej_q      <= 1'b0;
            for (int i = 0; i < N_REG; i++) regs_q[i] <= '0;
            regs_q[STATUS_ADDR] <= STATUS_RST;
        end else begin
            state_q    <= state_d;
            exc_code_q <= exc_code_d;
            exc_pc_q   <= exc_pc_d;
            rej_q      <= rej_d;
            regs_q     <= regs_d;
        end
    end

    // Exception beats ERET when both arrive together; the ERET is dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (exc_take)                          state_d = S_EXC;
                else if (!bus.EXC_REQ && bus.ERET_REQ) state_d = S_ERET;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY     = 1'b0;
        bus.EXC_ACK  = 1'b0;
        bus.ERET_ACK = 1'b0;
        unique case (state_q)
            S_EXC:   begin bus.BUSY = 1'b1; bus.EXC_ACK  = 1'b1; end
            S_ERET:  begin bus.BUSY = 1'b1; bus.ERET_ACK = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        exc_code_d = exc_take ? bus.EXC_CODE : exc_code_q;
        exc_pc_d   = exc_take ? bus.EXC_PC   : exc_pc_q;
        rej_d      = idle && bus.EXC_REQ && !ie;
    end

    // MTC0 commits first; an exception entering this edge overwrites next edge.
    always_comb begin
        regs_d = regs_q;
        if (wr_ok) regs_d[bus.CP0_RD[IDX_W-1:0]] = bus.WDATA;
        if (state_q == S_EXC) begin
            regs_d[EPC_ADDR]                     = exc_pc_q;
            regs_d[CAUSE_ADDR][CAUSE_HI:CAUSE_LO] = exc_code_q;
            regs_d[STATUS_ADDR]                  = regs_q[STATUS_ADDR] << STATUS_SH;
        end else if (state_q == S_ERET) begin
            regs_d[STATUS_ADDR] = regs_q[STATUS_ADDR] >> STATUS_SH;
        end
    end

endmodule

// File: tb/tb_cp0_regfile_ctrl.sv
// Directed scenarios followed by random traffic, checked against a
// cycle-level behavioural model of the CP0 bank (16 implemented registers).
module tb_cp0_regfile_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cp0_regfile_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    cp0_regfile_ctrl #(.DATA_W(32), .ADDR_W(5), .N_REG(16)) dut (
        .CLK(clk), .RST(rst), .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: register file, sequencer phase, latched request.
    logic [31:0] m_reg [16];
    int          m_st;      // 0 idle, 1 taking exception, 2 returning
    logic [4:0]  m_code;
    logic [31:0] m_pc;
    logic        m_rej;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_read();
        int a;
        if (bus.R_SEL_RD)          a = int'(bus.CP0_RD);
        else if (bus.R_SEL_STATUS) a = 12;
        else if (bus.R_SEL_EPC)    a = 14;
        else if (bus.R_SEL_CAUSE)  a = 13;
        else                       return 32'h0;
        return (a < 16) ? m_reg[a] : 32'h0;
    endfunction

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".busy"},   32'(bus.BUSY),     32'(m_st != 0));
        chk({tag, ".ack"},    32'(bus.EXC_ACK),  32'(m_st == 1));
        chk({tag, ".eack"},   32'(bus.ERET_ACK), 32'(m_st == 2));
        chk({tag, ".rej"},    32'(bus.EXC_REJ),  32'(m_rej));
        chk({tag, ".epc"},    bus.EPC_OUT,       m_reg[14]);
        chk({tag, ".status"}, bus.STATUS_OUT,    m_reg[12]);
        chk({tag, ".rdata"},  bus.RDATA,         m_read());
    endtask

    // Apply one clock edge to the model using the inputs presented now.
    task automatic tick();
        int nst;
        logic rejn;
        nst  = 0;
        rejn = 1'b0;
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 32'h0;
            m_reg[12] = 32'h1;
            m_code = '0;
            m_pc   = '0;
        end else if (m_st == 0) begin
            if (bus.EXC_REQ && m_reg[12][0]) begin
                nst = 1; m_code = bus.EXC_CODE; m_pc = bus.EXC_PC;
            end else if (bus.EXC_REQ) rejn = 1'b1;
            else if (bus.ERET_REQ) nst = 2;
            if (bus.MTC0 && int'(bus.CP0_RD) < 16) m_reg[int'(bus.CP0_RD)] = bus.WDATA;
        end else if (m_st == 1) begin
            m_reg[14] = m_pc;
            m_reg[13] = (m_reg[13] & ~32'h7C) | (32'(m_code) * 4);
            m_reg[12] = m_reg[12] * 32;
        end else begin
            m_reg[12] = m_reg[12] / 32;
        end
        m_st  = nst;
        m_rej = rejn;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.R_SEL_RD = 0; bus.R_SEL_STATUS = 0; bus.R_SEL_EPC = 0; bus.R_SEL_CAUSE = 0;
        bus.CP0_RD = '0; bus.MTC0 = 0; bus.WDATA = '0;
        bus.EXC_REQ = 0; bus.EXC_CODE = '0; bus.EXC_PC = '0; bus.ERET_REQ = 0;
    endtask

    task automatic rd_sel(input int which);
        bus.R_SEL_RD = (which == 0); bus.R_SEL_STATUS = (which == 1);
        bus.R_SEL_EPC = (which == 2); bus.R_SEL_CAUSE = (which == 3);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.MTC0 = 1; bus.CP0_RD = a; bus.WDATA = d;
        tick();
        bus.MTC0 = 0;
    endtask

    initial begin
        foreach (m_reg[i]) m_reg[i] = 32'h0;
        m_st = 0; m_rej = 0; m_code = '0; m_pc = '0;
        quiet();
        @(posedge clk); #1;

        // 1: reset values through each select
        rst = 1; tick(); rst = 0;
        check_all("rst");
        rd_sel(1); chk("rst.status_rd", bus.RDATA, 32'h1);
        rd_sel(2); chk("rst.epc_rd",    bus.RDATA, 32'h0);
        rd_sel(3); chk("rst.cause_rd",  bus.RDATA, 32'h0);
        rd_sel(4); chk("rst.nosel",     bus.RDATA, 32'h0);

        // 2: write EPC, read-during-write returns the old value
        bus.MTC0 = 1; bus.CP0_RD = 5'd14; bus.WDATA = 32'hDEADBEEF; rd_sel(0);
        chk("mtc0.same_cycle", bus.RDATA, 32'h0);
        tick(); bus.MTC0 = 0; #1;
        chk("mtc0.next_cycle", bus.RDATA, 32'hDEADBEEF);

        // 3: exception entry
        rd_sel(4);
        mtc0(5'd12, 32'h1);
        bus.EXC_REQ = 1; bus.EXC_CODE = 5'd8; bus.EXC_PC = 32'h0040_0020;
        tick(); bus.EXC_REQ = 0;
        check_all("exc.ack");
        chk("exc.ack_hi", 32'(bus.EXC_ACK), 32'h1);
        tick();
        rd_sel(3);
        chk("exc.epc",    bus.EPC_OUT,    32'h0040_0020);
        chk("exc.cause",  bus.RDATA,      32'h20);
        chk("exc.status", bus.STATUS_OUT, 32'h20);

        // 4: exception return
        bus.ERET_REQ = 1; tick(); bus.ERET_REQ = 0; #1;
        chk("eret.ack", 32'(bus.ERET_ACK), 32'h1);
        chk("eret.epc", bus.EPC_OUT, 32'h0040_0020);
        tick(); #1;
        chk("eret.status", bus.STATUS_OUT, 32'h1);
        check_all("eret.done");

        // 5: rejection with IE=0, then simultaneous EXC+ERET
        mtc0(5'd12, 32'h0);
        bus.EXC_REQ = 1; bus.EXC_CODE = 5'd9; tick(); bus.EXC_REQ = 0; #1;
        chk("rej.pulse", 32'(bus.EXC_REJ), 32'h1);
        chk("rej.busy",  32'(bus.BUSY),    32'h0);
        tick(); rd_sel(3);
        chk("rej.gone",  32'(bus.EXC_REJ), 32'h0);
        chk("rej.cause", bus.RDATA, 32'h20);
        mtc0(5'd12, 32'h1);
        bus.EXC_REQ = 1; bus.ERET_REQ = 1; bus.EXC_CODE = 5'd13; bus.EXC_PC = 32'h100;
        tick(); bus.EXC_REQ = 0; bus.ERET_REQ = 0; #1;
        chk("both.exc_ack",  32'(bus.EXC_ACK),  32'h1);
        chk("both.eret_ack", 32'(bus.ERET_ACK), 32'h0);
        tick(); #1;
        chk("both.cause", bus.RDATA, 32'h34);
        check_all("both.done");

        // 6: reset while in S_EXC, then write to an unimplemented address
        mtc0(5'd12, 32'h1);
        bus.EXC_REQ = 1; bus.EXC_PC = 32'h200; tick(); bus.EXC_REQ = 0;
        rst = 1; tick(); rst = 0; #1;
        chk("rstexc.ack", 32'(bus.EXC_ACK), 32'h0);
        chk("rstexc.epc", bus.EPC_OUT, 32'h0);
        check_all("rstexc");
        mtc0(5'd31, 32'hFFFF_FFFF);
        bus.CP0_RD = 5'd31; rd_sel(0);
        chk("unimpl.rd31", bus.RDATA, 32'h0);
        bus.CP0_RD = 5'd15; #1;
        chk("unimpl.rd15", bus.RDATA, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.MTC0     = ($urandom_range(0, 3) == 0);
            bus.CP0_RD   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(12, 14))
                                                       : 5'($urandom_range(0, 31));
            bus.WDATA    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            bus.EXC_REQ  = ($urandom_range(0, 4) == 0);
            bus.ERET_REQ = ($urandom_range(0, 4) == 0);
            bus.EXC_CODE = 5'($urandom);
            bus.EXC_PC   = $urandom;
            bus.R_SEL_RD     = ($urandom_range(0, 2) == 0);
            bus.R_SEL_STATUS = $urandom_range(0, 1) == 1;
            bus.R_SEL_EPC    = $urandom_range(0, 1) == 1;
            bus.R_SEL_CAUSE  = $urandom_range(0, 1) == 1;
            check_all("rnd");
            tick();
        end
        rst = 0; quiet();
        check_all("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
